multicycle_add_sub: RTL and testbench
=====================================

// Module: multicycle_add_sub
// PURPOSE
//  Parametrised adder/subtractor computing A+B or A-B over several cycles, CHUNK bits per cycle, LSB first.
//  The carry between chunks is held in a register.
//  Generalises the 4-bit ripple-carry add/sub to any WIDTH and adds a valid/ready handshake.
//  Adds carry-out/borrow and signed-overflow flags.
//  Sits between an operand source and a result sink in the datapath.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; WIDTH >= 2
//  CHUNK   4  bits processed per cycle; WIDTH % CHUNK == 0; NCHUNK = WIDTH/CHUNK
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands a, b, sub are valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: s = a + b; 1: s = a - b
//  out_valid  out  1      s, cout, ovf are valid
//  out_ready  in   1      sink accepts the result
//  s          out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of the MSB; when sub=1, 1 = no borrow (a >= b unsigned)
//  ovf        out  1      two's-complement overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, in_ready=1, out_valid=0, s=0, cout=0, ovf=0.
//   - Chunk index and carry register cleared.
//   - Reset mid-operation abandons the operation; no result is ever presented for it.
//  FSM states: IDLE, CALC, DONE.
//   - IDLE: in_ready=1. On in_valid&&in_ready:
//     - latch A=a, B=(sub ? ~b : b) and carry=sub;
//     - clear idx=0; go to CALC.
//   - CALC: in_ready=0, out_valid=0. Each cycle:
//     - {c, s[idx*CHUNK +: CHUNK]} = A_slice + B_slice + carry; carry <= c; idx++.
//     - On the slice where idx == NCHUNK-1: record cout=c, and ovf = carry into bit WIDTH-1 XOR c; go to DONE.
//   - DONE: out_valid=1, in_ready=0.
//     - s, cout and ovf are held stable while out_ready=0.
//     - On out_valid&&out_ready: go to IDLE; out_valid=0 the next cycle.
//  Latency:
//   - Operands accepted at edge k -> out_valid=1 after edge k+NCHUNK.
//   - Minimum issue interval: NCHUNK+2 cycles. in_ready only in IDLE, so there is no overlap of operations.
//  Input stability:
//   - a, b, sub are sampled only at acceptance.
//   - Changes during CALC or DONE have no effect.
//  Outputs during CALC:
//   - s is partially updated and undefined to the sink; the sink uses s only when out_valid=1.
//   - cout and ovf keep their previous values until the final slice.
//  Degenerate case CHUNK==WIDTH:
//   - NCHUNK=1; one CALC cycle, then DONE.
//  Boundary cases (follow the modulo rules above):
//   - 0-0 gives s=0, cout=1.
//   - Max+1 wraps.
//   - Most-negative minus 1 sets ovf.
//  in_valid held high during CALC or DONE:
//   - not accepted; the source keeps it asserted until in_ready.
//  All registers update only on the rising clk edge, except for the asynchronous reset.
// TESTING (WIDTH=16, CHUNK=4, so NCHUNK=4)
//  1. Addition, no carry and carry:
//     - sub=0, a=0x0005, b=0x0003 -> s=0x0008, cout=0, ovf=0; out_valid 4 cycles after accept.
//     - sub=0, a=0xFFFF, b=0x0001 -> s=0x0000, cout=1, ovf=0.
//  2. Addition, signed overflow:
//     - sub=0, a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1.
//  3. Subtraction, no borrow and borrow:
//     - sub=1, a=0x0005, b=0x0002 -> s=0x0003, cout=1, ovf=0.
//     - sub=1, a=0x0003, b=0x0005 -> s=0xFFFE, cout=0, ovf=0.
//     - sub=1, a=0x8000, b=0x0001 -> s=0x7FFF, cout=1, ovf=1.
//  4. Backpressure:
//     - Hold out_ready=0 for 5 cycles in DONE -> s, cout, ovf, out_valid stay stable and in_ready stays 0.
//     - Then out_ready=1 -> IDLE next cycle and in_ready=1.
//     - Also change a and b mid-CALC -> result unchanged.
//  5. Reset mid-operation:
//     - Assert rst_n=0 during the 2nd CALC cycle -> immediately out_valid=0, in_ready=1, s=0.
//     - The next operation (0x1234+0x1111) gives 0x2345.
//  6. Randomised back-to-back:
//     - 200 random operations with random sub and random in_valid/out_ready gaps, checked against a reference model.
//     - Repeat with CHUNK=16 and with CHUNK=1.

Source files
------------

// File: rtl/multicycle_add_sub_if.sv
// Operand/result handshake bundle for the multicycle adder/subtractor.
// The slave side is the arithmetic block; the master side is the source/sink.
interface multicycle_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/multicycle_add_sub.sv
// Chunked ripple adder/subtractor: CHUNK bits per cycle, LSB first, carry held
// between chunks, with valid/ready handshake plus carry-out and overflow flags.
module multicycle_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_add_sub_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [IDXW-1:0]  idx_q, idx_d;

    logic [CHUNK-1:0] a_sl_s;
    logic [CHUNK-1:0] b_sl_s;
    logic [CHUNK:0]   sum_s;
    logic             last_s;
    logic             msb_cin_s;
    logic             in_ready_s;
    logic             out_valid_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) state_d = CALC;
                else              state_d = IDLE;
            end
            CALC: begin
                if (last_s) state_d = DONE;
                else        state_d = CALC;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
                else               state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            IDLE:    in_ready_s  = 1'b1;
            CALC:    in_ready_s  = 1'b0;
            DONE:    out_valid_s = 1'b1;
            default: in_ready_s  = 1'b0;
        endcase
    end

    // Current chunk sum; the MSB carry-in is recovered from the slice MSB bits
    always_comb begin
        a_sl_s    = a_q[idx_q*CHUNK +: CHUNK];
        b_sl_s    = b_q[idx_q*CHUNK +: CHUNK];
        sum_s     = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{CHUNK{1'b0}}, carry_q};
        msb_cin_s = a_sl_s[CHUNK-1] ^ b_sl_s[CHUNK-1] ^ sum_s[CHUNK-1];
        last_s    = (idx_q == LAST_IDX);
    end

    // Datapath next-state: operand capture, chunk accumulate, final flags
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    idx_d   = {IDXW{1'b0}};
                end else begin
                    idx_d   = idx_q;
                end
            end
            CALC: begin
                s_d[idx_q*CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
                carry_d = sum_s[CHUNK];
                idx_d   = idx_q + IDXW'(1);
                if (last_s) begin
                    cout_d = sum_s[CHUNK];
                    ovf_d  = msb_cin_s ^ sum_s[CHUNK];
                end else begin
                    cout_d = cout_q;
                end
            end
            DONE:    s_d = s_q;
            default: s_d = s_q;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            s_q     <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= {IDXW{1'b0}};
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_multicycle_add_sub.sv
// Directed and randomised checks of multicycle_add_sub at CHUNK = 4, 16 and 1.
module tb_multicycle_add_sub;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    multicycle_add_sub_if #(.WIDTH(16)) if4  ();
    multicycle_add_sub_if #(.WIDTH(16)) if16 ();
    multicycle_add_sub_if #(.WIDTH(16)) if1  ();

    multicycle_add_sub #(.WIDTH(16), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    multicycle_add_sub #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    multicycle_add_sub #(.WIDTH(16), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full transaction; lat = edges from accept to out_valid, -1 on timeout
    task automatic do_op(input virtual multicycle_add_sub_if #(.WIDTH(16)) vif,
                         input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input int gap, input int rdy_dly,
                         output logic [15:0] s, output logic co, output logic ov,
                         output int lat);
        int cnt;
        for (int i = 0; i < gap; i++) @(negedge clk);
        vif.a = a; vif.b = b; vif.sub = sub; vif.in_valid = 1'b1;
        cnt = 0;
        while (!vif.in_ready && cnt < 100) begin @(negedge clk); cnt++; end
        @(posedge clk);
        @(negedge clk);
        vif.in_valid = 1'b0;
        lat = 0;
        while (!vif.out_valid && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
        if (!vif.out_valid || cnt >= 100) lat = -1;
        for (int i = 0; i < rdy_dly; i++) @(negedge clk);
        s = vif.s; co = vif.cout; ov = vif.ovf;
        vif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({if4.in_ready, if4.out_valid, if4.s, if4.cout, if4.ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset: got rdy=%b vld=%b s=%h c=%b o=%b want rdy=1 vld=0 s=0000 c=0 o=0",
                     if4.in_ready, if4.out_valid, if4.s, if4.cout, if4.ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] va [7] = '{16'h0005, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h0003, 16'h8000, 16'h0000};
        logic [15:0] vb [7] = '{16'h0003, 16'h0001, 16'h0001, 16'h0002, 16'h0005, 16'h0001, 16'h0000};
        logic        vs [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [17:0] ve [7] = '{{16'h0008, 1'b0, 1'b0}, {16'h0000, 1'b1, 1'b0}, {16'h8000, 1'b0, 1'b1},
                                {16'h0003, 1'b1, 1'b0}, {16'hFFFE, 1'b0, 1'b0}, {16'h7FFF, 1'b1, 1'b1},
                                {16'h0000, 1'b1, 1'b0}};
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            do_op(if4, va[i], vb[i], vs[i], 0, 0, s, co, ov, lat);
            total++;
            if ({s, co, ov} !== ve[i]) begin
                bad++;
                $display("FAIL directed[%0d]: got s=%h c=%b o=%b want s=%h c=%b o=%b",
                         i, s, co, ov, ve[i][17:2], ve[i][1], ve[i][0]);
            end
            total++;
            if (lat !== 4) begin
                bad++;
                $display("FAIL latency[%0d]: got %0d want 4", i, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int cnt;
        @(negedge clk);
        if4.a = 16'h1000; if4.b = 16'h0001; if4.sub = 1'b1; if4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.a = 16'hFFFF; if4.b = 16'hFFFF; if4.sub = 1'b0;
        cnt = 0;
        while (!if4.out_valid && cnt < 20) begin @(negedge clk); cnt++; end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({if4.out_valid, if4.in_ready, if4.s, if4.cout, if4.ovf} !== {1'b1, 1'b0, 16'h0FFF, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL hold[%0d]: got vld=%b rdy=%b s=%h c=%b o=%b want vld=1 rdy=0 s=0fff c=1 o=0",
                         i, if4.out_valid, if4.in_ready, if4.s, if4.cout, if4.ovf);
            end
            @(negedge clk);
        end
        if4.in_valid = 1'b0;
        if4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.out_ready = 1'b0;
        total++;
        if ({if4.out_valid, if4.in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL release: got vld=%b rdy=%b want vld=0 rdy=1", if4.out_valid, if4.in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        @(negedge clk);
        if4.a = 16'h1234; if4.b = 16'h1111; if4.sub = 1'b0; if4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({if4.out_valid, if4.in_ready, if4.s} !== {1'b0, 1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL reset_mid: got vld=%b rdy=%b s=%h want vld=0 rdy=1 s=0000",
                     if4.out_valid, if4.in_ready, if4.s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(if4, 16'h1234, 16'h1111, 1'b0, 1, 0, s, co, ov, lat);
        total++;
        if ({s, co, ov, lat} !== {16'h2345, 1'b0, 1'b0, 32'sd4}) begin
            bad++;
            $display("FAIL after_reset: got s=%h c=%b o=%b lat=%0d want s=2345 c=0 o=0 lat=4", s, co, ov, lat);
        end
    endtask

    task automatic test_random(input virtual multicycle_add_sub_if #(.WIDTH(16)) vif,
                               input int nchunk, input int n);
        logic [15:0] a, b, s, es;
        logic        sub, co, ov, ec, eo;
        logic [16:0] full;
        int          lat;
        for (int i = 0; i < n; i++) begin
            a   = 16'($urandom_range(0, 65535));
            b   = 16'($urandom_range(0, 65535));
            sub = 1'($urandom_range(0, 1));
            do_op(vif, a, b, sub, $urandom_range(0, 3), $urandom_range(0, 3), s, co, ov, lat);
            if (sub) begin
                es = a - b;
                ec = (a >= b);
                eo = (a[15] != b[15]) && (es[15] != a[15]);
            end else begin
                full = {1'b0, a} + {1'b0, b};
                es = full[15:0];
                ec = full[16];
                eo = (a[15] == b[15]) && (es[15] != a[15]);
            end
            total++;
            if ({s, co, ov} !== {es, ec, eo} || lat != nchunk) begin
                bad++;
                $display("FAIL random c%0d[%0d]: a=%h b=%h sub=%b got s=%h c=%b o=%b lat=%0d want s=%h c=%b o=%b lat=%0d",
                         nchunk, i, a, b, sub, s, co, ov, lat, es, ec, eo, nchunk);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        if4.in_valid = 1'b0;  if4.out_ready = 1'b0;  if4.a = 16'h0;  if4.b = 16'h0;  if4.sub = 1'b0;
        if16.in_valid = 1'b0; if16.out_ready = 1'b0; if16.a = 16'h0; if16.b = 16'h0; if16.sub = 1'b0;
        if1.in_valid = 1'b0;  if1.out_ready = 1'b0;  if1.a = 16'h0;  if1.b = 16'h0;  if1.sub = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random(if4, 4, 200);
        test_random(if16, 1, 200);
        test_random(if1, 16, 200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
